// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned SLICE_W = 4;
  localparam int unsigned OP_W    = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Only the arithmetic opcodes report a meaningful final carry.
  function automatic logic op_has_carry(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; every grant is an accept, so the pointer
// moves on any grant and hands priority to the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  logic prio_q;  // 1: req[1] wins a tie

  always_comb begin
    gnt_c = 2'b00;
    if (en) begin
      gnt_c[0] = req[0] & (~req[1] | ~prio_q);
      gnt_c[1] = req[1] & (~req[0] |  prio_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (|gnt_c) begin
      prio_q <= gnt_c[0];
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Arbitrates two requesters onto one shared 4-bit ALU slice and runs each
// operation LSB-first over NSLICE passes, chaining the carry between passes.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned NSLICE = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [OP_W-1:0]             req0_op,
  input  logic [SLICE_W*NSLICE-1:0]   req0_a,
  input  logic [SLICE_W*NSLICE-1:0]   req0_b,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [OP_W-1:0]             req1_op,
  input  logic [SLICE_W*NSLICE-1:0]   req1_a,
  input  logic [SLICE_W*NSLICE-1:0]   req1_b,
  output logic [SLICE_W-1:0]          alu_a,
  output logic [SLICE_W-1:0]          alu_b,
  output logic [OP_W-1:0]             alu_op,
  output logic                        alu_cin,
  input  logic [SLICE_W-1:0]          alu_res,
  input  logic                        alu_cout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_id,
  output logic [SLICE_W*NSLICE-1:0]   rsp_result,
  output logic                        rsp_cout
);

  localparam int unsigned W     = SLICE_W * NSLICE;
  localparam int unsigned CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   op_q;
  logic [W-1:0]      a_q, b_q;
  logic              carry_q;

  logic [1:0]        gnt_c;
  logic              arb_en_c;
  logic              accept_c;
  logic              last_c;
  logic              rsp_hs_c;
  logic [31:0]       slice_base_c;

  // Grants are only offered while idle and out of reset.
  assign arb_en_c = (state_q == ST_IDLE) & rst_n;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en_c),
    .req   ({req1_valid, req0_valid}),
    .gnt_c (gnt_c)
  );

  assign req0_ready   = gnt_c[0];
  assign req1_ready   = gnt_c[1];
  assign accept_c     = |gnt_c;
  assign last_c       = (cnt_q == LAST_SLICE);
  assign rsp_hs_c     = rsp_valid & rsp_ready;
  assign slice_base_c = SLICE_W * 32'(cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus slice drive; the ALU port is parked at zero unless running.
  always_comb begin
    state_d = state_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    alu_cin = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        alu_a   = SLICE_W'(a_q >> slice_base_c);
        alu_b   = SLICE_W'(b_q >> slice_base_c);
        alu_op  = op_q;
        alu_cin = (cnt_q == '0) ? (op_q == OP_SUB) : carry_q;
        if (last_c) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, slice capture and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            rsp_id  <= gnt_c[1];
            op_q    <= gnt_c[1] ? req1_op : req0_op;
            a_q     <= gnt_c[1] ? req1_a  : req0_a;
            b_q     <= gnt_c[1] ? req1_b  : req0_b;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt_q == CNT_W'(i)) rsp_result[i*SLICE_W +: SLICE_W] <= alu_res;
          end
          carry_q <= alu_cout;
          if (last_c) begin
            rsp_valid <= 1'b1;
            rsp_cout  <= op_has_carry(op_q) & alu_cout;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_hs_c) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: behavioural ALU slice, whole-word
// reference model, directed cases plus randomized two-requester traffic.
module tb_alu_seq_ctrl;

  localparam int unsigned NSLICE = 4;
  localparam int unsigned W      = 4 * NSLICE;
  localparam int          LAT    = NSLICE + 1;
  localparam logic [2:0]  ADD = 3'd0, SUB = 3'd1, ANDOP = 3'd2, OROP = 3'd3, XOROP = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic alu_cin, alu_cout;
  logic rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout;
  logic [W-1:0] rsp_result;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         cout;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rand_rdy = 1'b0;

  alu_seq_ctrl #(.NSLICE(NSLICE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 4-bit ALU slice; reserved opcodes give NAND with carry-out 1.
  logic [3:0] nb;
  always_comb begin
    nb = ~alu_b;
    alu_res  = '0;
    alu_cout = 1'b0;
    case (alu_op)
      ADD:     {alu_cout, alu_res} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
      SUB:     {alu_cout, alu_res} = 5'(alu_a) + 5'(nb) + 5'(alu_cin);
      ANDOP:   alu_res = alu_a & alu_b;
      OROP:    alu_res = alu_a | alu_b;
      XOROP:   alu_res = alu_a ^ alu_b;
      default: begin alu_res = ~(alu_a & alu_b); alu_cout = 1'b1; end
    endcase
  end

  // Whole-word reference: {cout, result}.
  function automatic logic [W:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {(a >= b), W'(a - b)};
      ANDOP:   return {1'b0, a & b};
      OROP:    return {1'b0, a | b};
      XOROP:   return {1'b0, a ^ b};
      default: return {1'b0, ~(a & b)};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  // Present one request, push its expected response at the accepting edge.
  task automatic issue(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    logic got;
    int waited;
    exp_t e;
    @(posedge clk); #1;
    drive(id, 1'b1, op, a, b);
    got = 1'b0;
    waited = 0;
    while (!got && waited < 500) begin
      @(negedge clk);
      if (rst_n && ((id == 0) ? req0_ready : req1_ready)) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      chk("accept_timeout", 32'(waited), 0);
    end else begin
      r = ref_alu(op, a, b);
      e.id = id[0]; e.res = r[W-1:0]; e.cout = r[W]; e.acc = cyc;
      exp_q.push_back(e);
      acc_log.push_back(id);
    end
    @(posedge clk); #1;
    drive(id, 1'b0, op, a, b);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 0);
  endtask

  // Monitor: latency, stability under back-pressure, idle ALU port, scoreboard.
  logic         prev_valid = 1'b0, prev_hs = 1'b0, prev_id = 1'b0, prev_cout = 1'b0;
  logic [W-1:0] prev_res = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (alu_op inside {ANDOP, OROP, XOROP}) chk("cin_logic_op", 32'(alu_cin), 0);
      if (rsp_valid) begin
        chk("ready_in_resp", 32'({req1_ready, req0_ready}), 0);
        chk("alu_idle_in_resp", 32'({alu_a, alu_b, alu_op, alu_cin}), 0);
        if (!prev_valid) begin
          if (exp_q.size() != 0) chk("latency", 32'(cyc), 32'(exp_q[0].acc + LAT));
        end else if (!prev_hs) begin
          chk("stall_result", 32'(rsp_result), 32'(prev_res));
          chk("stall_id", 32'(rsp_id), 32'(prev_id));
          chk("stall_cout", 32'(rsp_cout), 32'(prev_cout));
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_rsp", 32'(rsp_result), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_result", 32'(rsp_result), 32'(e.res));
            chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
          end
        end
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid & rsp_ready;
      prev_res   = rsp_result;
      prev_id    = rsp_id;
      prev_cout  = rsp_cout;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with both requesters already asserting valid.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_cout", 32'(rsp_cout), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op, alu_cin}), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst_n      = 1'b1;

    issue(0, ADD, 16'h00FF, 16'h0001); drain();
    issue(1, SUB, 16'h0000, 16'h0001); drain();
    issue(1, SUB, 16'h0005, 16'h0003); drain();
    issue(0, XOROP, 16'hA5A5, 16'hFFFF); drain();
    issue(1, 3'b110, 16'h0F0F, 16'h3C3C); drain();
    issue(0, 3'b111, 16'hFFFF, 16'h0001); drain();

    // Both requesters contend back-to-back: grants must alternate.
    acc_log.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, 3'($urandom_range(0, 4)), W'($urandom), W'($urandom));
      for (int j = 0; j < 4; j++) issue(1, 3'($urandom_range(0, 4)), W'($urandom), W'($urandom));
    join
    drain();
    chk("rr_count", 32'(acc_log.size()), 8);
    for (int k = 1; k < acc_log.size(); k++) chk("rr_alternate", 32'(acc_log[k]), 32'(acc_log[k-1] ^ 1));

    // Hold the response for 10 cycles while req1 waits.
    rsp_ready = 1'b0;
    issue(0, ADD, 16'h1234, 16'h4321);
    fork
      issue(1, SUB, 16'h8000, 16'h0001);
      begin
        int n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("stall_valid_held", 32'(rsp_valid), 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset pulse during slice 2 of an ADD must abort without a response.
    issue(0, ADD, 16'hFFFF, 16'h0001);
    @(posedge clk); #1;
    drive(1, 1'b1, ADD, 16'h1111, 16'h2222);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_rsp_result", 32'(rsp_result), 0);
    chk("abort_rsp_id", 32'(rsp_id), 0);
    chk("abort_rsp_cout", 32'(rsp_cout), 0);
    chk("abort_ready", 32'({req1_ready, req0_ready}), 0);
    chk("abort_alu", 32'({alu_a, alu_b, alu_op, alu_cin}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 1'b0, ADD, 16'h1111, 16'h2222);
    repeat (8) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 0);
    issue(0, ADD, 16'hFFFF, 16'h0001); drain();

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    fork
      for (int i = 0; i < 12; i++) begin
        issue(0, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      for (int j = 0; j < 12; j++) begin
        issue(1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    join
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
